// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe sequencer: takes moves, alternates turns, scans the
// 8 lines through a shared external checker, reports win or draw.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   new_game            synchronous clear, same effect as reset
//   move_valid/pos      move request and target cell 0..8
//   move_ready          high while waiting for a move
//   illegal_move        one-cycle pulse after a rejected move
//   chk_pos0/1/2        cell codes of the line being scanned
//   chk_winner/player   checker verdict for that line
//   board, turn         board cells (2 bits each) and player to move
//   scan_line           index of the line being scanned
//   game_over, winner_player, draw   end-of-game status
module tictactoe_game_ctrl #(
  parameter logic [1:0]  FIRST_PLAYER   = 2'b01,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  output logic        illegal_move,
  output logic [1:0]  chk_pos0,
  output logic [1:0]  chk_pos1,
  output logic [1:0]  chk_pos2,
  input  logic        chk_winner,
  input  logic [1:0]  chk_player,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [2:0]  scan_line,
  output logic        game_over,
  output logic [1:0]  winner_player,
  output logic        draw
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  count;
  logic [15:0] to_cnt;

  logic [1:0] cells [9];
  logic [1:0] cur_cell;
  logic [3:0] i0, i1, i2;
  logic       pos_ok;
  logic       accept;
  logic       legal;
  logic       bad;
  logic [1:0] flip;

  always_comb begin
    for (int i = 0; i < 9; i++)
      cells[i] = board[2*i +: 2];
  end

  assign pos_ok   = (move_pos <= 4'd8);
  assign cur_cell = pos_ok ? cells[move_pos] : 2'b00;

  assign move_ready = (state == S_WAIT);
  assign accept     = move_valid && move_ready;
  assign legal      = accept && pos_ok &&
                      (cur_cell == 2'b00);
  assign bad        = accept && !legal;
  assign flip       = {turn[0], turn[1]};

  always_comb begin
    i0 = 4'd0;
    i1 = 4'd1;
    i2 = 4'd2;
    case (scan_line)
      3'd0: begin i0 = 4'd0; i1 = 4'd1; i2 = 4'd2; end
      3'd1: begin i0 = 4'd3; i1 = 4'd4; i2 = 4'd5; end
      3'd2: begin i0 = 4'd6; i1 = 4'd7; i2 = 4'd8; end
      3'd3: begin i0 = 4'd0; i1 = 4'd3; i2 = 4'd6; end
      3'd4: begin i0 = 4'd1; i1 = 4'd4; i2 = 4'd7; end
      3'd5: begin i0 = 4'd2; i1 = 4'd5; i2 = 4'd8; end
      3'd6: begin i0 = 4'd0; i1 = 4'd4; i2 = 4'd8; end
      default: begin i0 = 4'd2; i1 = 4'd4; i2 = 4'd6; end
    endcase
  end

  assign chk_pos0 = cells[i0];
  assign chk_pos1 = cells[i1];
  assign chk_pos2 = cells[i2];

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state         <= S_WAIT;
      board         <= '0;
      turn          <= FIRST_PLAYER;
      count         <= '0;
      to_cnt        <= '0;
      scan_line     <= '0;
      game_over     <= 1'b0;
      winner_player <= 2'b00;
      draw          <= 1'b0;
      illegal_move  <= 1'b0;
    end else begin
      illegal_move <= bad;
      case (state)
        S_WAIT: begin
          if (legal) begin
            for (int i = 0; i < 9; i++)
              if (move_pos == 4'(i))
                board[2*i +: 2] <= turn;
            count     <= count + 4'd1;
            scan_line <= '0;
            to_cnt    <= '0;
            state     <= S_SCAN;
          end else if (TO_EN && to_cnt == TO_LAST) begin
            // forfeit: the other player moves next
            turn   <= flip;
            to_cnt <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_SCAN: begin
          if (chk_winner) begin
            // first winning line ends the scan
            state         <= S_OVER;
            game_over     <= 1'b1;
            winner_player <= chk_player;
          end else if (scan_line == 3'd7) begin
            if (count == 4'd9) begin
              state     <= S_OVER;
              game_over <= 1'b1;
              draw      <= 1'b1;
            end else begin
              scan_line <= '0;
              turn      <= flip;
              to_cnt    <= '0;
              state     <= S_WAIT;
            end
          end else begin
            scan_line <= scan_line + 3'd1;
          end
        end
        S_OVER: begin
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Directed bench for tictactoe_game_ctrl with a behavioural line
// checker and an expectation queue drained at each sample point.
module tb_tictactoe_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, new_game, move_valid;
  logic [3:0]  move_pos;
  logic        move_ready, illegal_move;
  logic [1:0]  cp0, cp1, cp2;
  logic        chk_winner;
  logic [1:0]  chk_player;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [2:0]  scan_line;
  logic        game_over, draw;
  logic [1:0]  winner_player;

  logic        reset2, new_game2, mv2;
  logic [3:0]  pos2;
  logic        ready2, illegal2;
  logic [1:0]  q0, q1, q2;
  logic        win2;
  logic [1:0]  pl2;
  logic [17:0] board2;
  logic [1:0]  turn2;
  logic [2:0]  scan2;
  logic        over2, draw2;
  logic [1:0]  wp2;

  function automatic logic line_win(
    input logic [1:0] a, b, c);
    return (a != 2'b00) && (a == b) && (b == c);
  endfunction

  assign chk_winner = line_win(cp0, cp1, cp2);
  assign chk_player = chk_winner ? cp0 : 2'b00;
  assign win2       = line_win(q0, q1, q2);
  assign pl2        = win2 ? q0 : 2'b00;

  tictactoe_game_ctrl dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .move_valid(move_valid), .move_pos(move_pos),
    .move_ready(move_ready),
    .illegal_move(illegal_move),
    .chk_pos0(cp0), .chk_pos1(cp1), .chk_pos2(cp2),
    .chk_winner(chk_winner), .chk_player(chk_player),
    .board(board), .turn(turn),
    .scan_line(scan_line), .game_over(game_over),
    .winner_player(winner_player), .draw(draw)
  );

  tictactoe_game_ctrl #(
    .FIRST_PLAYER(2'b01), .TIMEOUT_CYCLES(5)
  ) dut_to (
    .clk(clk), .reset(reset2), .new_game(new_game2),
    .move_valid(mv2), .move_pos(pos2),
    .move_ready(ready2), .illegal_move(illegal2),
    .chk_pos0(q0), .chk_pos1(q1), .chk_pos2(q2),
    .chk_winner(win2), .chk_player(pl2),
    .board(board2), .turn(turn2),
    .scan_line(scan2), .game_over(over2),
    .winner_player(wp2), .draw(draw2)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string tag,
                      input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty obs=%0h exp=none", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s obs=%0h exp=%0h",
               x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!move_ready && n < 20) begin
      tick();
      n++;
    end
    push("ready_wait", 32'd1);
    check(32'(move_ready));
  endtask

  task automatic play(input logic [3:0] p);
    wait_ready();
    move_valid = 1'b1;
    move_pos   = p;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic play_nowin(input logic [3:0] p);
    play(p);
    repeat (7) tick();
    push("ready_t8", 32'd0);
    check(32'(move_ready));
    tick();
    push("ready_t9", 32'd1);
    check(32'(move_ready));
  endtask

  task automatic restart();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    push("ng_board", 32'd0);
    check(32'(board));
    push("ng_turn", 32'd1);
    check(32'(turn));
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0;
    move_valid = 1'b0; move_pos = 4'd0;
    reset2 = 1'b1; new_game2 = 1'b0;
    mv2 = 1'b0; pos2 = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    push("rst_board", 32'd0);  check(32'(board));
    push("rst_turn", 32'd1);   check(32'(turn));
    push("rst_over", 32'd0);   check(32'(game_over));
    push("rst_ready", 32'd1);  check(32'(move_ready));
    push("rst_win", 32'd0);    check(32'(winner_player));
    push("rst_draw", 32'd0);   check(32'(draw));
    push("rst_ill", 32'd0);    check(32'(illegal_move));
    push("rst_scan", 32'd0);   check(32'(scan_line));

    // row 0 win by P1
    play_nowin(4'd0);
    play_nowin(4'd3);
    play_nowin(4'd1);
    play_nowin(4'd4);
    play(4'd2);
    push("w0_over_t1", 32'd0); check(32'(game_over));
    tick();
    push("w0_over_t2", 32'd1); check(32'(game_over));
    push("w0_winner", 32'd1);  check(32'(winner_player));
    push("w0_row0", 32'h15);   check(32'(board[5:0]));
    push("w0_ready", 32'd0);   check(32'(move_ready));
    push("w0_draw", 32'd0);    check(32'(draw));

    // moves ignored once over
    move_valid = 1'b1;
    move_pos   = 4'd5;
    tick();
    move_valid = 1'b0;
    push("over_ill", 32'd0);   check(32'(illegal_move));
    push("over_cell", 32'd0);  check(32'(board[11:10]));
    push("over_hold", 32'd1);  check(32'(winner_player));

    // draw
    restart();
    play_nowin(4'd0);
    play_nowin(4'd1);
    play_nowin(4'd2);
    play_nowin(4'd4);
    play_nowin(4'd3);
    play_nowin(4'd5);
    play_nowin(4'd7);
    play_nowin(4'd6);
    play(4'd8);
    repeat (7) tick();
    push("dr_over_t8", 32'd0); check(32'(game_over));
    tick();
    push("dr_over_t9", 32'd1); check(32'(game_over));
    push("dr_draw", 32'd1);    check(32'(draw));
    push("dr_winner", 32'd0);  check(32'(winner_player));

    // illegal moves
    restart();
    play_nowin(4'd4);
    push("il_turn0", 32'd2);   check(32'(turn));
    wait_ready();
    move_valid = 1'b1;
    move_pos   = 4'd4;
    tick();
    move_valid = 1'b0;
    push("il_occ_p", 32'd1);   check(32'(illegal_move));
    tick();
    push("il_occ_e", 32'd0);   check(32'(illegal_move));
    push("il_occ_t", 32'd2);   check(32'(turn));
    push("il_occ_b", 32'h100); check(32'(board));
    move_valid = 1'b1;
    move_pos   = 4'd9;
    tick();
    move_valid = 1'b0;
    push("il_9_p", 32'd1);     check(32'(illegal_move));
    tick();
    push("il_9_e", 32'd0);     check(32'(illegal_move));
    push("il_9_t", 32'd2);     check(32'(turn));
    push("il_9_b", 32'h100);   check(32'(board));
    push("il_ready", 32'd1);   check(32'(move_ready));

    // anti-diagonal win by P2
    restart();
    play_nowin(4'd0);
    play_nowin(4'd2);
    play_nowin(4'd1);
    play_nowin(4'd4);
    play_nowin(4'd8);
    play(4'd6);
    repeat (7) tick();
    push("ad_scan7", 32'd7);   check(32'(scan_line));
    push("ad_over_t8", 32'd0); check(32'(game_over));
    tick();
    push("ad_over_t9", 32'd1); check(32'(game_over));
    push("ad_winner", 32'd2);  check(32'(winner_player));
    push("ad_draw", 32'd0);    check(32'(draw));

    // new_game during scan with a move present
    restart();
    play(4'd0);
    tick();
    tick();
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd5;
    tick();
    new_game   = 1'b0;
    move_valid = 1'b0;
    push("ng_board0", 32'd0);  check(32'(board));
    push("ng_turn0", 32'd1);   check(32'(turn));
    push("ng_ready", 32'd1);   check(32'(move_ready));
    push("ng_over", 32'd0);    check(32'(game_over));
    tick();
    push("ng_drop", 32'd0);    check(32'(board));
    push("ng_ill", 32'd0);     check(32'(illegal_move));

    // turn timeout, illegal move mid-count
    tick();
    reset2 = 1'b0;
    push("to_c0", 32'd1);      check(32'(turn2));
    repeat (4) tick();
    push("to_c4", 32'd1);      check(32'(turn2));
    tick();
    push("to_c5", 32'd2);      check(32'(turn2));
    tick();
    tick();
    mv2  = 1'b1;
    pos2 = 4'd15;
    tick();
    mv2  = 1'b0;
    push("to_ill", 32'd1);     check(32'(illegal2));
    tick();
    push("to_c9", 32'd2);      check(32'(turn2));
    tick();
    push("to_c10", 32'd1);     check(32'(turn2));
    push("to_board", 32'd0);   check(32'(board2));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
